wb_cpu_bridge: RTL and testbench

- Wishbone master that turns single CPU-side bus requests (6507 13-bit address space) into Wishbone cycles on one of three slaves: TIA, RIOT RAM and PIA.
- Decodes the address, drives a per-slave strobe with a shared adr/dat/we bundle, and waits for that slave's ack.
- Returns read data and a one-cycle completion pulse to the CPU side.
- Sits between the CPU core and the existing Wishbone slaves, as the initiator end of their interface.

---
 rtl/wb_cpu_bridge.sv | 171 +++++++++++++++++
 tb/tb_wb_cpu_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_bridge.sv
// Wishbone master turning single 6507 CPU requests into cycles on TIA, RIOT RAM or PIA.
// Define WB_BRIDGE_TIMEOUT_EN to abandon stalled accesses after TIMEOUT_CYCLES and raise sticky err_o.
module wb_cpu_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [7:0]  UNMAPPED_DATA  = 8'hFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [12:0] cpu_adr,
   input  logic [7:0]  cpu_wdat,
   output logic        cpu_ready,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdat,
   output logic        err_o,
   output logic        wb_we_o,
   output logic [6:0]  wb_adr_o,
   output logic [7:0]  wb_dat_o,
   output logic        tia_stb_o,
   output logic        ram_stb_o,
   output logic        pia_stb_o,
   input  logic        tia_ack_i,
   input  logic        ram_ack_i,
   input  logic        pia_ack_i,
   input  logic [7:0]  tia_dat_i,
   input  logic [7:0]  ram_dat_i,
   input  logic [7:0]  pia_dat_i
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {SEL_NONE, SEL_TIA, SEL_RAM, SEL_PIA} sel_t;

   state_t     r_state;
   sel_t       r_sel;
   logic       r_we;
   logic [6:0] r_adr;
   logic [7:0] r_wdat;
   logic [7:0] r_rdat;
   logic       r_ack;
   logic       r_tia_stb;
   logic       r_ram_stb;
   logic       r_pia_stb;

   sel_t       w_dec_sel;
   logic [6:0] w_dec_adr;
   logic       w_sel_ack;
   logic [7:0] w_sel_dat;
   logic       w_unused_adr;

   // A11, A10 and A8 are don't-care in the 6507 mirror scheme
   assign w_unused_adr = ^{cpu_adr[11:10], cpu_adr[8]};

   always_comb begin
      w_dec_sel = SEL_NONE;
      w_dec_adr = 7'h00;
      if (cpu_adr[12]) begin
         w_dec_sel = SEL_NONE;
      end else if (!cpu_adr[7]) begin
         w_dec_sel = SEL_TIA;
         w_dec_adr = {1'b0, cpu_adr[5:0]};
      end else if (!cpu_adr[9]) begin
         w_dec_sel = SEL_RAM;
         w_dec_adr = cpu_adr[6:0];
      end else begin
         w_dec_sel = SEL_PIA;
         w_dec_adr = {2'b00, cpu_adr[4:0]};
      end
   end

   always_comb begin
      w_sel_ack = 1'b0;
      w_sel_dat = 8'h00;
      case (r_sel)
         SEL_TIA: begin w_sel_ack = tia_ack_i; w_sel_dat = tia_dat_i; end
         SEL_RAM: begin w_sel_ack = ram_ack_i; w_sel_dat = ram_dat_i; end
         SEL_PIA: begin w_sel_ack = pia_ack_i; w_sel_dat = pia_dat_i; end
         default: begin w_sel_ack = 1'b0;      w_sel_dat = 8'h00;     end
      endcase
   end

`ifdef WB_BRIDGE_TIMEOUT_EN
   localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_cnt;
   logic       r_err;
   assign err_o = r_err;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_sel     <= SEL_NONE;
         r_we      <= 1'b0;
         r_adr     <= 7'h00;
         r_wdat    <= 8'h00;
         r_rdat    <= 8'h00;
         r_ack     <= 1'b0;
         r_tia_stb <= 1'b0;
         r_ram_stb <= 1'b0;
         r_pia_stb <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
         r_cnt     <= 8'h00;
         r_err     <= 1'b0;
`endif
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cpu_req) begin
                  if (w_dec_sel == SEL_NONE) begin
                     r_rdat  <= UNMAPPED_DATA;
                     r_ack   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_sel     <= w_dec_sel;
                     r_we      <= cpu_we;
                     r_adr     <= w_dec_adr;
                     r_wdat    <= cpu_wdat;
                     r_tia_stb <= (w_dec_sel == SEL_TIA);
                     r_ram_stb <= (w_dec_sel == SEL_RAM);
                     r_pia_stb <= (w_dec_sel == SEL_PIA);
`ifdef WB_BRIDGE_TIMEOUT_EN
                     r_cnt     <= 8'h00;
`endif
                     r_state   <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // an ack coinciding with the last timeout cycle still completes normally
               if (w_sel_ack) begin
                  r_tia_stb <= 1'b0;
                  r_ram_stb <= 1'b0;
                  r_pia_stb <= 1'b0;
                  if (!r_we) r_rdat <= w_sel_dat;
                  r_ack     <= 1'b1;
                  r_state   <= S_DONE;
               end
`ifdef WB_BRIDGE_TIMEOUT_EN
               else if (r_cnt == LP_LAST) begin
                  r_tia_stb <= 1'b0;
                  r_ram_stb <= 1'b0;
                  r_pia_stb <= 1'b0;
                  r_rdat    <= UNMAPPED_DATA;
                  r_err     <= 1'b1;
                  r_ack     <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
`endif
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cpu_ready = (r_state == S_IDLE);
   assign cpu_ack   = r_ack;
   assign cpu_rdat  = r_rdat;
   assign wb_we_o   = r_we;
   assign wb_adr_o  = r_adr;
   assign wb_dat_o  = r_wdat;
   assign tia_stb_o = r_tia_stb;
   assign ram_stb_o = r_ram_stb;
   assign pia_stb_o = r_pia_stb;
endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Bench for wb_cpu_bridge: transaction-level model checked every cycle, directed cases, then random traffic.
module tb_wb_cpu_bridge;
   localparam int T = 4;
`ifdef WB_BRIDGE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [12:0] cpu_adr = 13'h0;
   logic [7:0]  cpu_wdat = 8'h0;
   logic        cpu_ready, cpu_ack, err_o, wb_we_o;
   logic [7:0]  cpu_rdat, wb_dat_o;
   logic [6:0]  wb_adr_o;
   logic        tia_stb_o, ram_stb_o, pia_stb_o;
   logic        tia_ack_i = 1'b0, ram_ack_i = 1'b0, pia_ack_i = 1'b0;
   logic [7:0]  tia_dat_i = 8'hA5, ram_dat_i = 8'h77, pia_dat_i = 8'h3C;

   int total = 0;
   int bad = 0;
   bit rand_mode = 1'b0;
   bit tia_block = 1'b0;

   wb_cpu_bridge #(.TIMEOUT_CYCLES(T), .UNMAPPED_DATA(8'hFF)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdat(cpu_wdat),
      .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_rdat(cpu_rdat), .err_o(err_o),
      .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .tia_stb_o(tia_stb_o), .ram_stb_o(ram_stb_o), .pia_stb_o(pia_stb_o),
      .tia_ack_i(tia_ack_i), .ram_ack_i(ram_ack_i), .pia_ack_i(pia_ack_i),
      .tia_dat_i(tia_dat_i), .ram_dat_i(ram_dat_i), .pia_dat_i(pia_dat_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Slaves register ack from the strobe seen before the edge; random mode adds stray acks and data.
   logic [2:0] s_stb = 3'b000;
   always @(negedge clk_i) s_stb = {tia_stb_o, ram_stb_o, pia_stb_o};
   always @(posedge clk_i) begin
      #1;
      if (rst_i) begin
         tia_ack_i = 1'b0; ram_ack_i = 1'b0; pia_ack_i = 1'b0;
      end else begin
         tia_ack_i = s_stb[2] ? (!tia_block && (!rand_mode || $urandom_range(0, 1) == 1))
                              : (rand_mode && $urandom_range(0, 7) == 0);
         ram_ack_i = s_stb[1] ? (!rand_mode || $urandom_range(0, 1) == 1)
                              : (rand_mode && $urandom_range(0, 7) == 0);
         pia_ack_i = s_stb[0] ? (!rand_mode || $urandom_range(0, 1) == 1)
                              : (rand_mode && $urandom_range(0, 7) == 0);
      end
      if (rand_mode) begin
         tia_dat_i = 8'($urandom); ram_dat_i = 8'($urandom); pia_dat_i = 8'($urandom);
      end else begin
         tia_dat_i = 8'hA5; ram_dat_i = 8'h77; pia_dat_i = 8'h3C;
      end
   end

   // Transaction-level reference: what the CPU and slaves must see next cycle.
   logic [2:0] m_stb = 3'b000;
   logic       m_ack = 1'b0, m_ready = 1'b1, m_err = 1'b0, m_busy = 1'b0, m_we = 1'b0;
   logic [7:0] m_rdat = 8'h00, m_wdat = 8'h00;
   logic [6:0] m_adr = 7'h00;
   int         m_waited = 0;

   always @(negedge clk_i) begin
      logic nxt_ack, sel_ack;
      logic [7:0] sel_dat;
      if (rst_i) begin
         m_stb = 3'b000; m_ack = 1'b0; m_ready = 1'b1; m_err = 1'b0;
         m_busy = 1'b0; m_rdat = 8'h00; m_waited = 0;
         chk("rst_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b000);
         chk("rst_ack", cpu_ack, 1'b0);
         chk("rst_rdat", cpu_rdat, 8'h00);
         chk("rst_err", err_o, 1'b0);
         chk("rst_ready", cpu_ready, 1'b1);
         chk("rst_wb", {wb_we_o, wb_adr_o, wb_dat_o}, 16'h0000);
      end else begin
         chk("stb", {tia_stb_o, ram_stb_o, pia_stb_o}, m_stb);
         chk("cpu_ack", cpu_ack, m_ack);
         chk("cpu_ready", cpu_ready, m_ready);
         chk("cpu_rdat", cpu_rdat, m_rdat);
         chk("err", err_o, m_err);
         if (m_stb != 3'b000) begin
            chk("wb_adr", wb_adr_o, m_adr);
            chk("wb_we", wb_we_o, m_we);
            if (m_we) chk("wb_dat", wb_dat_o, m_wdat);
         end
         sel_ack = (m_stb[2] & tia_ack_i) | (m_stb[1] & ram_ack_i) | (m_stb[0] & pia_ack_i);
         sel_dat = m_stb[2] ? tia_dat_i : (m_stb[1] ? ram_dat_i : pia_dat_i);
         nxt_ack = 1'b0;
         if (m_ready && cpu_req) begin
            m_ready = 1'b0;
            if (cpu_adr >= 13'h1000) begin
               nxt_ack = 1'b1;
               m_rdat  = 8'hFF;
            end else begin
               m_we = cpu_we; m_wdat = cpu_wdat; m_waited = 0; m_busy = 1'b1;
               if (cpu_adr % 256 < 128) begin
                  m_stb = 3'b100; m_adr = 7'(cpu_adr % 64);
               end else if ((cpu_adr / 512) % 2 == 0) begin
                  m_stb = 3'b010; m_adr = 7'(cpu_adr % 128);
               end else begin
                  m_stb = 3'b001; m_adr = 7'(cpu_adr % 32);
               end
            end
         end else if (m_busy) begin
            m_waited++;
            if (sel_ack) begin
               m_busy = 1'b0; m_stb = 3'b000; nxt_ack = 1'b1;
               if (!m_we) m_rdat = sel_dat;
            end else if (TO_EN && m_waited == T) begin
               m_busy = 1'b0; m_stb = 3'b000; nxt_ack = 1'b1;
               m_rdat = 8'hFF; m_err = 1'b1;
            end
         end else if (m_ack) begin
            m_ready = 1'b1;
         end
         m_ack = nxt_ack;
      end
   end

   // Presents a request and holds it until accepted; returns just after the accepting edge.
   task automatic do_access(input logic we, input logic [12:0] adr, input logic [7:0] wd);
      int n = 0;
      @(posedge clk_i); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdat = wd;
      @(negedge clk_i);
      while (!cpu_ready && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!cpu_ready) chk("accept_ready", cpu_ready, 1'b1);
      @(posedge clk_i); #1;
      cpu_req = 1'b0;
   endtask

   task automatic wait_ack(input string nm);
      int n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!cpu_ack && n < 100);
      chk(nm, cpu_ack, 1'b1);
   endtask

   initial begin
      int cnt;
      logic [12:0] a;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // PIA read 0x284
      do_access(1'b0, 13'h0284, 8'h00);
      @(negedge clk_i);
      chk("d1_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b001);
      chk("d1_adr", wb_adr_o, 7'h04);
      chk("d1_we", wb_we_o, 1'b0);
      @(negedge clk_i);
      chk("d1_early_ack", cpu_ack, 1'b0);
      @(negedge clk_i);
      chk("d1_ack", cpu_ack, 1'b1);
      chk("d1_rdat", cpu_rdat, 8'h3C);

      // PIA write 0x296
      do_access(1'b1, 13'h0296, 8'h40);
      @(negedge clk_i);
      chk("d2_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b001);
      chk("d2_adr", wb_adr_o, 7'h16);
      chk("d2_dat", wb_dat_o, 8'h40);
      chk("d2_we", wb_we_o, 1'b1);
      repeat (2) @(negedge clk_i);
      chk("d2_ack", cpu_ack, 1'b1);
      chk("d2_rdat_kept", cpu_rdat, 8'h3C);
      @(negedge clk_i);
      chk("d2_ack_once", cpu_ack, 1'b0);

      // RAM write then TIA read, back to back
      do_access(1'b1, 13'h0080, 8'h55);
      @(negedge clk_i);
      chk("d3_ram_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b010);
      chk("d3_ram_adr", wb_adr_o, 7'h00);
      do_access(1'b0, 13'h000D, 8'h00);
      @(negedge clk_i);
      chk("d3_tia_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b100);
      chk("d3_tia_adr", wb_adr_o, 7'h0D);
      wait_ack("d3_ack");
      chk("d3_rdat", cpu_rdat, 8'hA5);

      // unmapped read
      do_access(1'b0, 13'h1FFC, 8'h00);
      @(negedge clk_i);
      chk("d4_ack", cpu_ack, 1'b1);
      chk("d4_rdat", cpu_rdat, 8'hFF);
      chk("d4_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b000);
      chk("d4_err", err_o, 1'b0);

`ifdef WB_BRIDGE_TIMEOUT_EN
      tia_block = 1'b1;
      do_access(1'b0, 13'h000D, 8'h00);
      cnt = 0;
      repeat (8) begin
         @(negedge clk_i);
         if (tia_stb_o) cnt++;
      end
      chk("d5_stb_cycles", cnt, T);
      chk("d5_rdat", cpu_rdat, 8'hFF);
      chk("d5_err", err_o, 1'b1);
      tia_block = 1'b0;
      do_access(1'b0, 13'h0284, 8'h00);
      wait_ack("d5_good_ack");
      chk("d5_err_sticky", err_o, 1'b1);
      chk("d5_good_rdat", cpu_rdat, 8'h3C);
`endif

      // async reset in the middle of a stalled access
      tia_block = 1'b1;
      do_access(1'b0, 13'h0005, 8'h00);
      repeat (2) @(negedge clk_i);
      chk("d6_pre_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b100);
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      chk("d6_async_stb", {tia_stb_o, ram_stb_o, pia_stb_o}, 3'b000);
      chk("d6_async_ack", cpu_ack, 1'b0);
      chk("d6_async_ready", cpu_ready, 1'b1);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      tia_block = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         chk("d6_no_ack", cpu_ack, 1'b0);
      end
      chk("d6_ready", cpu_ready, 1'b1);

      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         a = 13'($urandom_range(0, 8191));
         if ($urandom_range(0, 3) != 0) a[12] = 1'b0;
         do_access(1'($urandom_range(0, 1)), a, 8'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk_i);
      end
      repeat (20) @(negedge clk_i);
      chk("end_idle", cpu_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
